// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: operation selects and FSM states.
// ALU_PIPE_MUL_EN adds the EXEC state used by the iterative multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_SGTI = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ANDI = 4'h6,
    OP_ORI  = 4'h7,
    OP_XORI = 4'h8,
    OP_ADDI = 4'h9,
    OP_SUBI = 4'hA,
    OP_MUL  = 4'hB,
    OP_SLT  = 4'hC
  } alu_op_e;

  localparam alu_op_e OP_DEFAULT = OP_ADD;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;
`else
  typedef enum logic {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } state_e;
`endif

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bundle between a requester and the pipelined ALU.
// master = requester side, slave = ALU side.
interface alu_pipe_if #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           Select;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [IMM_WIDTH-1:0] Imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     Result;
  logic                 zero;
  logic                 busy;

  modport master (
    output in_valid, Select, a, b, Imm, out_ready,
    input  in_ready, out_valid, Result, zero, busy
  );

  modport slave (
    input  in_valid, Select, a, b, Imm, out_ready,
    output in_ready, out_valid, Result, zero, busy
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock,
// done pulses one cycle after the last of WIDTH iterations.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             run;

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
        run    <= 1'b1;
      end else if (run) begin
        if (mplier[0])
          acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result; 1-cycle ops stream back to back.
// ALU_PIPE_MUL_EN enables the iterative multiply on select 1011.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 4
) (
  input logic       clock,
  input logic       reset,
  alu_pipe_if.slave bus
);
  state_e           state;
  state_e           state_nx;
  state_e           acc_nx;
  alu_op_e          op;
  logic [WIDTH-1:0] imm_x;
  logic [WIDTH-1:0] alu_r;
  logic [WIDTH-1:0] res_q;
  logic             accept;
  logic             mul_req;

  assign imm_x        = WIDTH'(bus.Imm);
  assign bus.in_ready = (state == S_IDLE) ||
                        (state == S_DONE && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.Result    = res_q;
  assign bus.zero      = (res_q == '0);

  // Multiply is never decoded here; it falls to the default op.
  always_comb begin
    op = OP_DEFAULT;
    unique case (bus.Select)
      OP_ADD, OP_SUB, OP_SGTI, OP_AND,
      OP_OR, OP_XOR, OP_ANDI, OP_ORI,
      OP_XORI, OP_ADDI, OP_SUBI, OP_SLT:
        op = alu_op_e'(bus.Select);
      default: op = OP_DEFAULT;
    endcase
  end

  always_comb begin
    alu_r = bus.a + bus.b;
    unique case (op)
      OP_SUB:  alu_r = bus.a - bus.b;
      OP_SGTI: alu_r = WIDTH'(bus.b > imm_x);
      OP_AND:  alu_r = bus.a & bus.b;
      OP_OR:   alu_r = bus.a | bus.b;
      OP_XOR:  alu_r = bus.a ^ bus.b;
      OP_ANDI: alu_r = bus.b & imm_x;
      OP_ORI:  alu_r = bus.b | imm_x;
      OP_XORI: alu_r = bus.b ^ imm_x;
      OP_ADDI: alu_r = bus.b + imm_x;
      OP_SUBI: alu_r = bus.b - imm_x;
      OP_SLT:  alu_r = WIDTH'($signed(bus.a) < $signed(bus.b));
      default: alu_r = bus.a + bus.b;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;

  assign mul_req = (bus.Select == OP_MUL);
  assign acc_nx  = mul_req ? S_EXEC : S_DONE;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (accept && mul_req),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_p)
  );
`else
  assign mul_req = 1'b0;
  assign acc_nx  = S_DONE;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (accept) state_nx = acc_nx;
      S_DONE:
        if (accept)             state_nx = acc_nx;
        else if (bus.out_ready) state_nx = S_IDLE;
`ifdef ALU_PIPE_MUL_EN
      S_EXEC:
        if (mul_done) state_nx = S_DONE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      res_q <= '0;
    end else begin
      state <= state_nx;
      if (accept && !mul_req)
        res_q <= alu_r;
`ifdef ALU_PIPE_MUL_EN
      else if (state == S_EXEC && mul_done)
        res_q <= mul_p;
`endif
    end
  end

endmodule
